fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction-fetch stage between program_counter and decode.
//  Issues instruction reads to the icache at the current PC.
//  Queues {pc, npc, instr} in a small FIFO for the decoder.
//  Returns pc_en to the PC register as its advance enable (PC ihit input).
//  Flush discards queued and in-flight fetches on branch/jump/JR redirect.
// PARAMETERS
//  DEPTH  2  queue entries; power of 2, >= 2
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   reset, asynchronous, active-low
//  pcaddr     in   32  current PC from program_counter
//  pc_en      out  1   PC advance enable; 1 = accepted fetch at pcaddr
//  iREN       out  1   icache read request
//  iaddr      out  32  icache read address
//  ihit       in   1   icache response; iload valid this cycle
//  iload      in   32  fetched instruction word
//  flush      in   1   redirect: drop queue and in-flight fetch
//  out_valid  out  1   queue head valid
//  out_ready  in   1   decode accepts head this cycle
//  out_pc     out  32  head PC
//  out_npc    out  32  head PC + 4, modulo 2^32
//  out_instr  out  32  head instruction
// BEHAVIOUR
//  Reset (async, nRST=0):
//   state=FETCH; queue empty; rd/wr ptr=0; count=0.
//   out_valid=0; pc_en=0; iREN=0; iaddr=0; out_* data=0.
//  States:
//   FETCH:
//    iREN = !full | pop; iaddr = pcaddr.
//    Accept = ihit & iREN & !flush.
//    On accept: push {pcaddr, pcaddr+4, iload}; pc_en=1 (comb, same cycle).
//    flush & iREN & !ihit -> DISCARD, latching pcaddr into hold_addr.
//   DISCARD:
//    iREN=1; iaddr=hold_addr, held until ihit.
//    On ihit: data dropped, pc_en=0 -> FETCH.
//    Further flush in DISCARD: no effect.
//  Handshake:
//   pop = out_valid & out_ready & !flush.
//   Head stable while out_valid & !out_ready.
//   out_* is registered queue head (no iload bypass).
//   Instruction is visible to decode >= 1 cycle after its ihit.
//  Full: count==DEPTH.
//   Push when full only with a same-cycle pop (count unchanged).
//   Otherwise iREN=0 and pc_en=0.
//  Empty: out_valid=0; out_ready ignored.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  Flush (any state): at next edge count=0, pointers=0, out_valid=0.
//   Flush takes priority over same-cycle push/pop.
//   pc_en=0 during flush; program_counter loads the redirect itself.
//   First fetch at the new PC is issued the cycle after flush.
//  Reset mid-request: cache reply after reset is ignored unless iREN=1.
//  npc: 32-bit add, carry discarded.
// TESTING
//  1. Reset, pcaddr=0, ihit every cycle, out_ready=1:
//     out_pc 0,4,8..., one/cycle; out_npc=out_pc+4; pc_en=1 continuous.
//  2. out_ready=0, ihit=1, DEPTH=2:
//     2 pushes then pc_en=0, iREN=0.
//     out_ready=1 one cycle -> exactly one pop + one push.
//  3. ihit every 3rd cycle, decode always ready:
//     iaddr held stable while waiting; pc_en pulses only with ihit.
//     Queue never exceeds 1 entry.
//  4. Flush with iREN=1, ihit=0, pcaddr=0x40:
//     DISCARD, iaddr=0x40 held; late ihit (iload=0xDEAD) never appears.
//     Next fetch uses new pcaddr.
//  5. Flush with queue full and out_ready=1:
//     no pop that cycle; out_valid=0 next cycle; count=0.
//  6. nRST=0 mid-wait:
//     all outputs 0 immediately (async); FETCH resumes at pcaddr=0.
//     pcaddr=0xFFFFFFFC fetch -> out_npc=0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Fetch stage: reads the icache at pcaddr and queues {pc, npc, instr} for decode; pc_en is asserted in the same cycle as an accepted ihit.
// Decode sees an entry one cycle after its ihit. A full queue with no pop holds iREN/pc_en low. Flush drops all entries and any in-flight read.
module fetch_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] pcaddr,
   output logic        pc_en,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_npc,
   output logic [31:0] out_instr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        hold_addr_q, hold_addr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        pc_mem_q    [DEPTH];
   logic [31:0]        pc_mem_d    [DEPTH];
   logic [31:0]        npc_mem_q   [DEPTH];
   logic [31:0]        npc_mem_d   [DEPTH];
   logic [31:0]        instr_mem_q [DEPTH];
   logic [31:0]        instr_mem_d [DEPTH];

   logic full;
   logic push;
   logic pop;
   logic iren;
   logic [31:0] iaddr_c;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready & ~flush;

   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_npc   = npc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];

   // Request side and state transitions.
   always_comb begin
      state_d     = state_q;
      hold_addr_d = hold_addr_q;
      iren        = 1'b0;
      iaddr_c     = '0;
      push        = 1'b0;
      case (state_q)
         FETCH: begin
            iren    = ~full | pop;
            iaddr_c = pcaddr;
            push    = ihit & iren & ~flush;
            // A read left outstanding by a redirect must be drained before refetching.
            if (flush & iren & ~ihit) begin
               state_d     = DISCARD;
               hold_addr_d = pcaddr;
            end
         end
         DISCARD: begin
            iren    = 1'b1;
            iaddr_c = hold_addr_q;
            if (ihit) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
      // Outputs read as zero for as long as reset is held, not just after the edge.
      if (!nRST) begin
         iren    = 1'b0;
         iaddr_c = '0;
         push    = 1'b0;
      end
   end

   assign iREN  = iren;
   assign iaddr = iaddr_c;
   assign pc_en = push;

   // Queue bookkeeping; flush wins over any same-cycle push or pop.
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      pc_mem_d    = pc_mem_q;
      npc_mem_d   = npc_mem_q;
      instr_mem_d = instr_mem_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = pcaddr;
            npc_mem_d[wr_ptr_q]   = pcaddr + 32'd4;
            instr_mem_d[wr_ptr_q] = iload;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= FETCH;
         hold_addr_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            npc_mem_q[i]   <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         hold_addr_q <= hold_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         pc_mem_q    <= pc_mem_d;
         npc_mem_q   <= npc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: queue-level reference model plus scoreboard of expected decode entries.
module tb_fetch_buffer;

   localparam int DEPTH = 2;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] pcaddr;
   logic        pc_en;
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_npc;
   logic [31:0] out_instr;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .pcaddr    (pcaddr),
      .pc_en     (pc_en),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .ihit      (ihit),
      .iload     (iload),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_npc   (out_npc),
      .out_instr (out_instr)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] instr;
   } entry_t;

   entry_t      sb[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model state: entries held, waiting-out-stale-read flag, its address, and the PC register.
   int          m_cnt;
   bit          m_disc;
   logic [31:0] m_hold;
   logic [31:0] pc;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_iREN"},      {31'd0, iREN},      32'd0);
      chk({tag, "_pc_en"},     {31'd0, pc_en},     32'd0);
      chk({tag, "_iaddr"},     iaddr,              32'd0);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_pc"},    out_pc,             32'd0);
      chk({tag, "_out_npc"},   out_npc,            32'd0);
      chk({tag, "_out_instr"}, out_instr,          32'd0);
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 3))
         0:       t = 32'h0000_0040;
         1:       t = 32'hFFFF_FFFC;
         2:       t = 32'hFFFF_FFF8;
         default: t = $urandom & 32'hFFFF_FFFC;
      endcase
      return t;
   endfunction

   // Monitor: whenever decode sees a valid head, it must match the oldest expected entry.
   initial begin
      entry_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (nRST && out_valid) begin
            if (sb.size() == 0) begin
               chk("head_unexpected", {31'd0, out_valid}, 32'd0);
            end else begin
               e = sb[0];
               chk("out_pc",    out_pc,    e.pc);
               chk("out_npc",   out_npc,   e.npc);
               chk("out_instr", out_instr, e.instr);
               if (out_ready && !flush) void'(sb.pop_front());
            end
         end
      end
   end

   // Phase profiles: ihit %, out_ready %, flush %, reset per-mille.
   int hit_pct   [6] = '{100, 100,  33,  50,  30,  80};
   int rdy_pct   [6] = '{100,  20, 100,  50,  70,  60};
   int flush_pct [6] = '{  0,   0,   0,  10,  15,   5};
   int rst_pm    [6] = '{  0,   0,   0,   0,  10,  10};

   initial begin
      bit          e_valid, e_pop, e_iren, e_pcen;
      logic [31:0] e_iaddr;
      entry_t      ne;

      nRST      = 1'b0;
      pcaddr    = '0;
      ihit      = 1'b1;
      iload     = 32'h1234_5678;
      flush     = 1'b0;
      out_ready = 1'b1;
      m_cnt     = 0;
      m_disc    = 1'b0;
      m_hold    = '0;
      pc        = '0;

      repeat (3) begin
         @(negedge CLK);
         #1;
         chk_all_zero("reset");
      end

      for (int ph = 0; ph < 6; ph++) begin
         for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            if (!nRST) nRST = 1'b1;
            pcaddr    = pc;
            ihit      = ($urandom_range(0, 99) < hit_pct[ph]);
            out_ready = ($urandom_range(0, 99) < rdy_pct[ph]);
            flush     = ($urandom_range(0, 99) < flush_pct[ph]);
            iload     = m_disc ? 32'h0000_DEAD : $urandom;
            #2;

            e_valid = (m_cnt > 0);
            e_pop   = e_valid && out_ready && !flush;
            if (m_disc) begin
               e_iren  = 1'b1;
               e_iaddr = m_hold;
               e_pcen  = 1'b0;
            end else begin
               e_iren  = (m_cnt < DEPTH) || e_pop;
               e_iaddr = pc;
               e_pcen  = ihit && e_iren && !flush;
            end
            chk("iREN",      {31'd0, iREN},      {31'd0, e_iren});
            chk("iaddr",     iaddr,              e_iaddr);
            chk("pc_en",     {31'd0, pc_en},     {31'd0, e_pcen});
            chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});

            if (m_disc) begin
               if (ihit) m_disc = 1'b0;
            end else if (flush && e_iren && !ihit) begin
               m_disc = 1'b1;
               m_hold = pc;
            end
            if (flush) begin
               m_cnt = 0;
               sb.delete();
            end else begin
               if (e_pcen) begin
                  ne.pc    = pc;
                  ne.npc   = pc + 32'd4;
                  ne.instr = iload;
                  sb.push_back(ne);
                  m_cnt++;
               end
               if (e_pop) m_cnt--;
            end
            if (flush) pc = pick_target();
            else if (e_pcen) pc = pc + 32'd4;

            if ($urandom_range(0, 999) < rst_pm[ph]) begin
               #1;
               nRST   = 1'b0;
               ihit   = 1'b1;
               flush  = 1'b0;
               pcaddr = '0;
               pc     = '0;
               m_cnt  = 0;
               m_disc = 1'b0;
               sb.delete();
               #1;
               chk_all_zero("async_reset");
            end
         end
         // Seed the next phase with a near-wrap PC so the npc carry-out case is exercised.
         if (ph == 2 && !flush) begin
            @(negedge CLK);
            nRST   = 1'b0;
            pc     = 32'hFFFF_FFF4;
            m_cnt  = 0;
            m_disc = 1'b0;
            sb.delete();
         end
      end

      @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
